jk_decoder: RTL and testbench

- USB full-speed receive front end: recovers NRZI bits from the dp/dn line, sampled 4x at 48 MHz.
- Detects SYNC, removes stuffed bits, detects EOP, and flags line errors.
- Sits between the pad inputs and the byte assembler / packet parser. Mirror of the transmit-side JK encoder.

---
 rtl/jk_decoder.sv | 199 +++++++++++++++++++
 tb/tb_jk_decoder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_decoder.sv
// USB full-speed receive front end: dp/dn synchronizer, 4x clock recovery,
// NRZI decode, SYNC detection, bit unstuffing, EOP detection and error reporting.
module jk_decoder #(
    parameter int unsigned SYNC_MIN_ZEROS = 5,
    parameter int unsigned EOP_MAX_SE0    = 3
) (
    input  logic       clk48,
    input  logic       reset,
    input  logic       dp,
    input  logic       dn,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       rx_active,
    output logic       eop,
    output logic       rx_error,
    output logic [1:0] err_code
);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned PH_W  = 2;
    localparam logic [1:0] ERR_SYNC  = 2'd1;
    localparam logic [1:0] ERR_STUFF = 2'd2;
    localparam logic [1:0] ERR_EOP   = 2'd3;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PAYLOAD,
        ST_EOP,
        ST_ERROR
    } state_t;

    // SE1 folds into SE0 because neither differential bit is set alone
    function automatic line_t to_line(input logic [1:0] d);
        return line_t'({d[1] & ~d[0], d[0] & ~d[1]});
    endfunction

    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    line_t            line_q, line_d, line_c, prev_q, prev_d;
    logic [PH_W-1:0]  phase_q, phase_d, phase_c;
    logic             sample_c, dbit_c, is_se0_c, is_j_c;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] zero_q, zero_d, ones_q, ones_d, se0_q, se0_d;
    logic             bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
    logic             rx_active_q, rx_active_d, eop_q, eop_d, rx_error_q, rx_error_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             err_go_c;
    logic [1:0]       err_val_c;

    // Synchronizer and phase recovery; a line change restarts the bit phase
    always_comb begin
        sync1_d  = {dp, dn};
        sync2_d  = sync1_q;
        line_c   = to_line(sync2_q);
        line_d   = line_c;
        phase_c  = (line_c != line_q) ? '0 : phase_q;
        phase_d  = phase_c + PH_W'(1);
        sample_c = (phase_c == PH_W'(2));
        dbit_c   = (line_c == prev_q);
        is_se0_c = (line_c == LS_SE0);
        is_j_c   = (line_c == LS_J);
    end

    // Packet FSM: next state and registered outputs
    always_comb begin
        state_d     = state_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        se0_d       = se0_q;
        prev_d      = prev_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        eop_d       = 1'b0;
        rx_error_d  = 1'b0;
        rx_active_d = rx_active_q;
        err_code_d  = err_code_q;
        err_go_c    = 1'b0;
        err_val_c   = 2'd0;
        if (sample_c) begin
            prev_d = line_c;
            unique case (state_q)
                ST_IDLE: begin
                    if (line_c == LS_K) begin
                        state_d = ST_SYNC;
                        zero_d  = CNT_W'(1);
                    end
                end
                ST_SYNC: begin
                    if (is_se0_c) begin
                        err_go_c  = 1'b1;
                        err_val_c = ERR_SYNC;
                    end else if (!dbit_c) begin
                        if (zero_q != CNT_W'(7)) zero_d = zero_q + CNT_W'(1);
                    end else if (zero_q >= CNT_W'(SYNC_MIN_ZEROS)) begin
                        state_d     = ST_PAYLOAD;
                        rx_active_d = 1'b1;
                        ones_d      = CNT_W'(1);
                        err_code_d  = 2'd0;
                    end else begin
                        err_go_c  = 1'b1;
                        err_val_c = ERR_SYNC;
                    end
                end
                ST_PAYLOAD: begin
                    if (is_se0_c) begin
                        state_d = ST_EOP;
                        se0_d   = CNT_W'(1);
                    end else if (ones_q == CNT_W'(6)) begin
                        if (!dbit_c) begin
                            ones_d = '0;
                        end else begin
                            err_go_c  = 1'b1;
                            err_val_c = ERR_STUFF;
                        end
                    end else begin
                        bit_out_d   = dbit_c;
                        bit_valid_d = 1'b1;
                        ones_d      = dbit_c ? ones_q + CNT_W'(1) : '0;
                    end
                end
                ST_EOP: begin
                    if (is_se0_c) begin
                        if (se0_q >= CNT_W'(EOP_MAX_SE0)) begin
                            err_go_c  = 1'b1;
                            err_val_c = ERR_EOP;
                        end else begin
                            se0_d = se0_q + CNT_W'(1);
                        end
                    end else if (is_j_c) begin
                        eop_d       = 1'b1;
                        rx_active_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        err_go_c  = 1'b1;
                        err_val_c = ERR_EOP;
                    end
                end
                ST_ERROR: begin
                    if (is_j_c) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (err_go_c) begin
                state_d     = ST_ERROR;
                rx_error_d  = 1'b1;
                rx_active_d = 1'b0;
                err_code_d  = err_val_c;
            end
        end
    end

    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            line_q      <= LS_SE0;
            phase_q     <= '0;
            prev_q      <= LS_J;
            state_q     <= ST_IDLE;
            zero_q      <= '0;
            ones_q      <= '0;
            se0_q       <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            rx_active_q <= 1'b0;
            eop_q       <= 1'b0;
            rx_error_q  <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            line_q      <= line_d;
            phase_q     <= phase_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            se0_q       <= se0_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            rx_active_q <= rx_active_d;
            eop_q       <= eop_d;
            rx_error_q  <= rx_error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign rx_active = rx_active_q;
    assign eop       = eop_q;
    assign rx_error  = rx_error_q;
    assign err_code  = err_code_q;
endmodule

// File: tb/tb_jk_decoder.sv
// Testbench for jk_decoder: builds line traffic from payload bits with a
// transmit-side NRZI/stuffing encoder and checks decoded events against a queue.
`timescale 1ns/1ps
module tb_jk_decoder;
    localparam logic [1:0] SJ   = 2'b10;
    localparam logic [1:0] SK   = 2'b01;
    localparam logic [1:0] SSE0 = 2'b00;
    localparam logic [1:0] SSE1 = 2'b11;
    localparam int EV_EOP = 10;
    localparam int EV_ERR = 20;

    logic clk48 = 1'b0;
    logic reset;
    logic dp, dn;
    logic bit_out, bit_valid, rx_active, eop, rx_error;
    logic [1:0] err_code;

    jk_decoder #(.SYNC_MIN_ZEROS(5), .EOP_MAX_SE0(3)) dut (
        .clk48(clk48), .reset(reset), .dp(dp), .dn(dn),
        .bit_out(bit_out), .bit_valid(bit_valid), .rx_active(rx_active),
        .eop(eop), .rx_error(rx_error), .err_code(err_code)
    );

    always #10 clk48 = ~clk48;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_q[$];
    int exp_err;
    logic [1:0] sym_q[$];
    int len_q[$];
    bit pl_q[$];
    logic [1:0] lvl;
    int ones;
    int n_bv, n_eop, n_err;
    logic [15:0] cap;
    int mark_idx = -1;
    time t_mark, t_bv1;
    int kind, nb, head;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Decoded-event monitor: every strobe must match the head of the model queue
    task automatic monitor();
        forever begin
            @(negedge clk48);
            if (!reset) begin
                if (eop || rx_error) chk("eop_err_exclusive", int'(eop & rx_error), 0);
                if (bit_valid) begin
                    if (n_bv == 1) t_bv1 = $time;
                    n_bv++;
                    cap = {bit_out, cap[15:1]};
                    chk("rx_active_on_bit", int'(rx_active), 1);
                    head = (exp_q.size() > 0) ? exp_q[0] : -1;
                    chk("bit_event", int'(bit_out), head);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (eop) begin
                    n_eop++;
                    head = (exp_q.size() > 0) ? exp_q[0] : -1;
                    chk("eop_event", EV_EOP + int'(err_code), head);
                    chk("rx_active_after_eop", int'(rx_active), 0);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (rx_error) begin
                    n_err++;
                    head = (exp_q.size() > 0) ? exp_q[0] : -1;
                    chk("error_event", EV_ERR + int'(err_code), head);
                    chk("rx_active_after_err", int'(rx_active), 0);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic tx_bit(input bit b, input int per);
        if (!b) lvl = (lvl == SJ) ? SK : SJ;
        sym_q.push_back(lvl);
        len_q.push_back(per);
    endtask

    task automatic tx_sync(input int nz);
        for (int i = 0; i < nz; i++) tx_bit(1'b0, 4);
        tx_bit(1'b1, 4);
        ones = 1;
    endtask

    task automatic add_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) pl_q.push_back(v[i]);
    endtask

    // Payload with transmit-side stuffing; alt selects 3/5-cycle bit periods
    task automatic tx_payload(input bit alt);
        bit b;
        int per;
        for (int i = 0; i < pl_q.size(); i++) begin
            b = pl_q[i];
            per = alt ? (((i % 2) == 0) ? 3 : 5) : 4;
            tx_bit(b, per);
            exp_q.push_back(int'(b));
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                tx_bit(1'b0, 4);
                ones = 0;
            end
        end
        pl_q.delete();
    endtask

    task automatic tx_stuff_err();
        tx_bit(1'b0, 4);
        exp_q.push_back(0);
        for (int i = 0; i < 7; i++) tx_bit(1'b1, 4);
        for (int i = 0; i < 6; i++) exp_q.push_back(1);
        exp_q.push_back(EV_ERR + 2);
    endtask

    task automatic tx_sym(input logic [1:0] s, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sym_q.push_back(s);
            len_q.push_back(4);
        end
    endtask

    task automatic tx_eop(input int nse0, input bit se1);
        tx_sym(se1 ? SSE1 : SSE0, nse0);
        if (nse0 <= 3) exp_q.push_back(EV_EOP);
        else begin
            exp_q.push_back(EV_ERR + 3);
            exp_err = 3;
        end
    endtask

    task automatic play(input int stop_at);
        for (int i = 0; i < sym_q.size(); i++) begin
            if (stop_at >= 0 && i == stop_at) break;
            if (i == mark_idx) t_mark = $time;
            {dp, dn} = sym_q[i];
            repeat (len_q[i]) @(negedge clk48);
        end
        sym_q.delete();
        len_q.delete();
    endtask

    task automatic finish_packet();
        tx_sym(SJ, 12);
        lvl = SJ;
        play(-1);
        chk("queue_drained", exp_q.size(), 0);
        chk("rx_active_idle", int'(rx_active), 0);
        chk("err_code_held", int'(err_code), exp_err);
    endtask

    task automatic start_test();
        n_bv = 0;
        n_eop = 0;
        n_err = 0;
        cap = '0;
    endtask

    task automatic good_packet(input logic [7:0] v, input int nz, input int nse0);
        tx_sync(nz);
        exp_err = 0;
        add_byte(v);
        tx_payload(1'b0);
        tx_eop(nse0, 1'b0);
        finish_packet();
    endtask

    initial begin
        reset = 1'b1;
        dp = 1'b1;
        dn = 1'b0;
        lvl = SJ;
        exp_err = 0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk48);
        chk("reset_bit_out", int'(bit_out), 0);
        chk("reset_bit_valid", int'(bit_valid), 0);
        chk("reset_rx_active", int'(rx_active), 0);
        chk("reset_eop", int'(eop), 0);
        chk("reset_rx_error", int'(rx_error), 0);
        chk("reset_err_code", int'(err_code), 0);
        reset = 1'b0;
        repeat (8) @(negedge clk48);

        // 1: 0xA5 after standard SYNC, plus pin-to-strobe latency
        start_test();
        mark_idx = 9;
        good_packet(8'hA5, 7, 2);
        mark_idx = -1;
        chk("t1_strobes", n_bv, 8);
        chk("t1_byte", int'(cap[15:8]), 8'hA5);
        chk("t1_eops", n_eop, 1);
        chk("t1_latency_ns", int'(t_bv1 - t_mark), 100);

        // 2: stuffed bit after six ones, counting the SYNC trailing one
        start_test();
        tx_sync(7);
        exp_err = 0;
        add_byte(8'hFF);
        add_byte(8'h01);
        tx_payload(1'b0);
        tx_eop(2, 1'b0);
        finish_packet();
        chk("t2_strobes", n_bv, 16);
        chk("t2_word", int'(cap), 16'h01FF);
        chk("t2_errors", n_err, 0);

        // 3: seven ones without a transition, then a clean packet
        start_test();
        tx_sync(7);
        exp_err = 2;
        add_byte(8'h3C);
        tx_payload(1'b0);
        tx_stuff_err();
        tx_sym(SSE0, 2);
        finish_packet();
        chk("t3_errors", n_err, 1);
        chk("t3_eops", n_eop, 0);
        chk("t3_code", int'(err_code), 2);
        start_test();
        good_packet(8'hA5, 7, 2);
        chk("t3_next_byte", int'(cap[15:8]), 8'hA5);

        // 4: truncated SYNC KJKK
        start_test();
        tx_sync(3);
        exp_q.push_back(EV_ERR + 1);
        exp_err = 1;
        finish_packet();
        chk("t4_strobes", n_bv, 0);
        chk("t4_code", int'(err_code), 1);

        // 5: 0x55 with 3/5-cycle bit periods, then a 4-bit-time SE0
        start_test();
        tx_sync(7);
        exp_err = 0;
        add_byte(8'h55);
        tx_payload(1'b1);
        tx_eop(4, 1'b0);
        finish_packet();
        chk("t5_byte", int'(cap[15:8]), 8'h55);
        chk("t5_code", int'(err_code), 3);

        // 6: asynchronous reset mid-payload, then a clean packet
        start_test();
        tx_sync(7);
        add_byte(8'hA5);
        tx_payload(1'b0);
        tx_eop(2, 1'b0);
        play(12);
        chk("t6_active_before_reset", int'(rx_active), 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_active", int'(rx_active), 0);
        chk("t6_rst_valid", int'(bit_valid), 0);
        chk("t6_rst_bit_out", int'(bit_out), 0);
        exp_q.delete();
        {dp, dn} = SJ;
        lvl = SJ;
        @(negedge clk48);
        repeat (3) @(negedge clk48);
        reset = 1'b0;
        repeat (8) @(negedge clk48);
        chk("t6_no_pulses", n_eop + n_err, 0);
        start_test();
        good_packet(8'hA5, 7, 2);
        chk("t6_byte", int'(cap[15:8]), 8'hA5);
        chk("t6_eops", n_eop, 1);

        // 7: boundaries: shortest accepted SYNC and longest accepted EOP
        start_test();
        good_packet(8'hC3, 5, 3);
        chk("t7_byte", int'(cap[15:8]), 8'hC3);

        // Randomized traffic mix
        for (int it = 0; it < 40; it++) begin
            start_test();
            kind = $urandom_range(0, 9);
            nb = $urandom_range(1, 3);
            if (kind == 7) begin
                tx_sync($urandom_range(1, 4));
                exp_q.push_back(EV_ERR + 1);
                exp_err = 1;
            end else begin
                tx_sync($urandom_range(5, 7));
                exp_err = 0;
                for (int b = 0; b < nb; b++)
                    add_byte(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
                tx_payload(1'b0);
                if (kind == 6) begin
                    tx_stuff_err();
                    exp_err = 2;
                    tx_sym(SSE0, 2);
                end else if (kind == 8) begin
                    tx_eop($urandom_range(4, 10), 1'($urandom_range(0, 1)));
                end else if (kind == 9) begin
                    tx_sym(SSE0, $urandom_range(1, 2));
                    tx_sym(SK, 1);
                    exp_q.push_back(EV_ERR + 3);
                    exp_err = 3;
                end else begin
                    tx_eop($urandom_range(1, 3), 1'($urandom_range(0, 1)));
                end
            end
            finish_packet();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
